// File: rtl/pic_port_io.sv
// rtl/pic_port_io.sv - PIC16C5x bidirectional I/O port: TRIS, output latch, input sync, read, change detect
//
// Purpose:
//   Core-side responder for one PIC16C5x I/O port. Holds the TRIS register
//   and output latch, drives the pad output data/enable, synchronises the
//   asynchronous pad inputs, returns pin state on a port read and raises a
//   sticky flag when an input pin moves away from the value seen at the
//   last read.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous active-high reset
//   tris_we      in   1      TRIS strobe, loads wdata into TRIS
//   port_we      in   1      port write strobe, loads wdata into output latch
//   port_re      in   1      port read strobe, captures pin state into rdata
//   wdata        in   WIDTH  write data from the core
//   rdata        out  WIDTH  registered read data (pin state)
//   pad_in       in   WIDTH  asynchronous pin values from the pads
//   pad_out      out  WIDTH  output latch value to the pads
//   pad_oe       out  WIDTH  per-bit output enable, 1 = drive
//   change_flag  out  1      sticky input-change indicator
//   change_clr   in   1      clears change_flag (a same-cycle change wins)

module pic_port_io #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tris_we,
    input  logic             port_we,
    input  logic             port_re,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             change_flag,
    input  logic             change_clr
);

    logic [WIDTH-1:0] r_tris;
    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_snapshot;
    logic [WIDTH-1:0] r_rdata;
    logic             r_change_flag;
    logic             w_mismatch;

    // TRIS: 1 = input. Reset leaves every pin floating as an input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tris <= '1;
        end else if (tris_we) begin
            r_tris <= wdata;
        end
    end

    // Output latch is independent of TRIS: writes land even on input bits
    // and become visible on the pin once the bit is turned into an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_latch <= '0;
        end else if (port_we) begin
            r_latch <= wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    // A read returns pin state (sync2) for every bit, output bits included,
    // and samples it before any same-cycle write can affect the pins.
    // The snapshot taken at the read is the reference for change detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= '0;
            r_snapshot <= '0;
        end else if (port_re) begin
            r_rdata    <= r_sync2;
            r_snapshot <= r_sync2;
        end
    end

    // Only input-configured bits can report a change.
    assign w_mismatch = |((r_sync2 ^ r_snapshot) & r_tris);

    // Set has priority over clear so a change coinciding with the clear
    // is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_change_flag <= 1'b0;
        end else if (w_mismatch) begin
            r_change_flag <= 1'b1;
        end else if (change_clr) begin
            r_change_flag <= 1'b0;
        end
    end

    assign pad_oe      = ~r_tris;
    assign pad_out     = r_latch;
    assign rdata       = r_rdata;
    assign change_flag = r_change_flag;

endmodule

// File: tb/tb_pic_port_io.sv
// tb/tb_pic_port_io.sv - self-checking bench for pic_port_io with a pin-history reference model

module tb_pic_port_io;

    logic       clk;
    logic       rst;
    logic       tris_we;
    logic       port_we;
    logic       port_re;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] pad_in;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic       change_flag;
    logic       change_clr;

    int checks   = 0;
    int failures = 0;

    pic_port_io #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tris_we     (tris_we),
        .port_we     (port_we),
        .port_re     (port_re),
        .wdata       (wdata),
        .rdata       (rdata),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .change_flag (change_flag),
        .change_clr  (change_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pin state seen by the core is the pad value
    // sampled two clock edges earlier; hist holds the pad samples per edge.
    logic [7:0] m_tris, m_latch, m_rdata, m_snap;
    logic       m_flag;
    logic [7:0] hist[$];

    function automatic logic [24:0] expected_outputs();
        return {~m_tris, m_latch, m_rdata, m_flag};
    endfunction

    // One clock: drive inputs after the falling edge, advance the model at
    // the rising edge, leave time 1 unit past the edge for sampling.
    task automatic step(input logic r, input logic tw, input logic pw, input logic re,
                        input logic clr, input logic [7:0] wd, input logic [7:0] pin);
        logic [7:0] pin_state;
        logic       changed;
        @(negedge clk);
        rst = r; tris_we = tw; port_we = pw; port_re = re;
        change_clr = clr; wdata = wd; pad_in = pin;
        @(posedge clk);
        if (r) begin
            m_tris = 8'hFF; m_latch = 8'h00; m_rdata = 8'h00;
            m_snap = 8'h00; m_flag = 1'b0;
            hist = '{8'h00, 8'h00};
        end else begin
            pin_state = hist[hist.size()-2];
            changed   = (((pin_state ^ m_snap) & m_tris) != 8'h00);
            if (re) begin
                m_rdata = pin_state;
                m_snap  = pin_state;
            end
            if (changed)  m_flag = 1'b1;
            else if (clr) m_flag = 1'b0;
            if (tw) m_tris  = wd;
            if (pw) m_latch = wd;
            hist.push_back(pin);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 8'h00, 8'h00);
            checks++;
            if ({pad_oe, pad_out, rdata, change_flag} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: oe=%h out=%h rdata=%h flag=%b expected 00 00 00 0",
                         i, pad_oe, pad_out, rdata, change_flag);
            end
        end
    endtask

    task automatic test_write_and_loopback();
        step(0, 0, 1, 0, 0, 8'hA5, 8'h00);
        checks++;
        if (pad_out !== 8'hA5 || pad_oe !== 8'h00) begin
            failures++;
            $display("FAIL latch_write: out=%h oe=%h expected A5 00", pad_out, pad_oe);
        end
        step(0, 1, 0, 0, 0, 8'h0F, 8'h00);
        checks++;
        if (pad_oe !== 8'hF0 || pad_out !== 8'hA5) begin
            failures++;
            $display("FAIL tris_write: oe=%h out=%h expected F0 A5", pad_oe, pad_out);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'h00, 8'hA3);
        checks++;
        if (rdata !== 8'hA3) begin
            failures++;
            $display("FAIL loopback_read: rdata=%h expected A3", rdata);
        end
    endtask

    task automatic test_read_latency();
        step(0, 1, 0, 0, 0, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 8'h00, 8'h3C);
            checks++;
            if (rdata !== ((i == 2) ? 8'h3C : 8'h00)) begin
                failures++;
                $display("FAIL read_latency edge %0d: rdata=%h expected %h",
                         i + 1, rdata, (i == 2) ? 8'h3C : 8'h00);
            end
        end
    endtask

    task automatic test_change_detect();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00, 8'h55);
        step(0, 0, 0, 1, 0, 8'h00, 8'h55);
        step(0, 0, 0, 0, 1, 8'h00, 8'h55);
        checks++;
        if (change_flag !== 1'b0) begin
            failures++;
            $display("FAIL change_pre_clear: flag=%b expected 0", change_flag);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 8'h00, 8'h54);
            checks++;
            if (change_flag !== (i == 2)) begin
                failures++;
                $display("FAIL change_latency edge %0d: flag=%b expected %b",
                         i + 1, change_flag, (i == 2));
            end
        end
        step(0, 0, 0, 0, 1, 8'h00, 8'h54);
        checks++;
        if (change_flag !== 1'b1) begin
            failures++;
            $display("FAIL change_set_wins: flag=%b expected 1", change_flag);
        end
        step(0, 0, 0, 1, 0, 8'h00, 8'h54);
        step(0, 0, 0, 0, 1, 8'h00, 8'h54);
        checks++;
        if (change_flag !== 1'b0) begin
            failures++;
            $display("FAIL change_clear: flag=%b expected 0", change_flag);
        end
    endtask

    task automatic test_output_bit_masked();
        step(0, 1, 0, 0, 0, 8'hFE, 8'h54);
        step(0, 0, 0, 1, 0, 8'h00, 8'h54);
        step(0, 0, 0, 0, 1, 8'h00, 8'h54);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 8'h00, 8'h55);
            checks++;
            if (change_flag !== 1'b0) begin
                failures++;
                $display("FAIL output_bit_masked edge %0d: flag=%b expected 0", i + 1, change_flag);
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00, 8'hD5);
        checks++;
        if (change_flag !== 1'b1) begin
            failures++;
            $display("FAIL input_bit7_change: flag=%b expected 1", change_flag);
        end
    endtask

    task automatic test_reset_overrides();
        step(0, 1, 1, 0, 0, 8'h3C, 8'h99);
        step(0, 0, 0, 1, 0, 8'h00, 8'h99);
        step(1, 1, 1, 1, 0, 8'hFF, 8'hFF);
        checks++;
        if ({pad_oe, pad_out, rdata, change_flag} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_overrides: oe=%h out=%h rdata=%h flag=%b expected 00 00 00 0",
                     pad_oe, pad_out, rdata, change_flag);
        end
    endtask

    task automatic test_random();
        logic [7:0] pin;
        logic [24:0] exp_v;
        pin = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), 8'($urandom), pin);
            exp_v = expected_outputs();
            checks++;
            if ({pad_oe, pad_out, rdata, change_flag} !== exp_v) begin
                failures++;
                $display("FAIL random cycle %0d: oe=%h out=%h rdata=%h flag=%b expected oe=%h out=%h rdata=%h flag=%b",
                         i, pad_oe, pad_out, rdata, change_flag,
                         exp_v[24:17], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; tris_we = 1'b0; port_we = 1'b0; port_re = 1'b0;
        change_clr = 1'b0; wdata = 8'h00; pad_in = 8'h00;
        test_reset();
        test_write_and_loopback();
        test_read_latency();
        test_change_detect();
        test_output_bit_masked();
        test_reset_overrides();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
